lycan_tx_arbiter: RTL and testbench

- Round-robin scheduler sharing the single host-bound (USB TX) path among N peripheral TX FIFOs.
- Pops words from the granted peripheral FIFO, stamps the peripheral address into the header bits, and writes them into the lycan_out FIFO drained by the FT601 controller.
- Bursts are bounded so no peripheral can monopolise the link.

---
 rtl/lycan_pkg.sv | 17 +
 rtl/lycan_tx_arbiter_rr_pick.sv | 51 +++++
 rtl/lycan_tx_arbiter.sv | 129 ++++++++++++
 tb/tb_lycan_tx_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lycan_pkg.sv
// Shared types and constants for the lycan host-bound TX arbiter.
package lycan_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int LYCAN_WORD_W   = 32;
    localparam int LYCAN_ADDR_MSB = LYCAN_WORD_W - 1;

    // Lowest bit of the address field stamped into the top of each word.
    function automatic int lycanAddrLsb(input int addrW);
        return LYCAN_WORD_W - addrW;
    endfunction

endpackage

// File: rtl/lycan_tx_arbiter_rr_pick.sv
// Round-robin selector: rotates the request vector so the slot after the
// last grant sits at bit 0, takes the lowest set bit, then rotates back.
module rr_pick
    import lycan_pkg::*;
#(
    parameter int NUM_PERIPH = 8,
    parameter int ADDR_W     = 3
) (
    input  logic [NUM_PERIPH-1:0] req_i,
    input  logic [ADDR_W-1:0]     last_i,
    output logic [ADDR_W-1:0]     gnt_idx_o,
    output logic                  gnt_any_o
);

    localparam logic [ADDR_W:0] NP_W = (ADDR_W+1)'(NUM_PERIPH);

    logic [ADDR_W-1:0]       startIdx;
    logic [2*NUM_PERIPH-1:0] doubled;
    logic [NUM_PERIPH-1:0]   rotated;
    logic [ADDR_W-1:0]       offset;
    logic [ADDR_W:0]         sumIdx;

    // Search starts one past the last grant, wrapping from the top slot to 0.
    always_comb begin
        if ({1'b0, last_i} >= (NP_W - 1'b1)) begin
            startIdx = '0;
        end else begin
            startIdx = last_i + ADDR_W'(1);
        end
    end

    // Rotate, priority-encode the lowest request, and map back to a slot.
    always_comb begin
        doubled = {req_i, req_i};
        rotated = NUM_PERIPH'(doubled >> startIdx);
        offset  = '0;
        for (int i = NUM_PERIPH - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = ADDR_W'(i);
            end
        end
        sumIdx = {1'b0, startIdx} + {1'b0, offset};
        if (sumIdx >= NP_W) begin
            gnt_idx_o = ADDR_W'(sumIdx - NP_W);
        end else begin
            gnt_idx_o = ADDR_W'(sumIdx);
        end
        gnt_any_o = |rotated;
    end

endmodule

// File: rtl/lycan_tx_arbiter.sv
// Round-robin TX arbiter: grants one peripheral FIFO at a time, moves up to
// MAX_BURST words per grant into the lycan_out FIFO, stamping the address.
module lycan_tx_arbiter
    import lycan_pkg::*;
#(
    parameter int NUM_PERIPH = 8,
    parameter int ADDR_W     = 3,
    parameter int MAX_BURST  = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         periph_ready_i,
    input  logic [NUM_PERIPH-1:0]        periph_en_i,
    input  logic [NUM_PERIPH-1:0]        periph_empty_i,
    input  logic [NUM_PERIPH*32-1:0]     periph_data_i,
    output logic [NUM_PERIPH-1:0]        periph_rd_en_o,
    input  logic                         out_full_i,
    output logic                         out_wr_en_o,
    output logic [LYCAN_WORD_W-1:0]      out_data_o,
    output logic                         grant_valid_o,
    output logic [ADDR_W-1:0]            grant_idx_o,
    output logic                         busy_o
);

    localparam int              CNT_W      = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST);
    localparam int              ADDR_LSB   = lycanAddrLsb(ADDR_W);

    arb_state_t          state_q;
    logic [ADDR_W-1:0]   grantIdx_q;
    logic [ADDR_W-1:0]   lastGrant_q;
    logic [CNT_W-1:0]    burstCnt_q;
    logic [CNT_W-1:0]    burstCnt_d;
    logic                grantValid_q;
    logic                busy_q;

    logic [NUM_PERIPH-1:0] eligible;
    logic [ADDR_W-1:0]     pickIdx;
    logic                  pickAny;
    logic [LYCAN_WORD_W-1:0] headWord;
    logic                  curEn;
    logic                  curEmpty;
    logic                  popNow;

    assign eligible = periph_en_i & ~periph_empty_i & {NUM_PERIPH{periph_ready_i}};

    rr_pick #(
        .NUM_PERIPH (NUM_PERIPH),
        .ADDR_W     (ADDR_W)
    ) uPick (
        .req_i     (eligible),
        .last_i    (lastGrant_q),
        .gnt_idx_o (pickIdx),
        .gnt_any_o (pickAny)
    );

    // Select the granted peripheral's head word and flags.
    always_comb begin
        headWord = '0;
        curEn    = 1'b0;
        curEmpty = 1'b1;
        for (int i = 0; i < NUM_PERIPH; i++) begin
            if (grantIdx_q == ADDR_W'(i)) begin
                headWord = periph_data_i[i*32 +: 32];
                curEn    = periph_en_i[i];
                curEmpty = periph_empty_i[i];
            end
        end
    end

    // Pop and write together whenever the granted FIFO has data and the sink has room.
    always_comb begin
        popNow         = (state_q == BURST) && periph_ready_i && curEn && !curEmpty && !out_full_i;
        burstCnt_d     = burstCnt_q + CNT_W'(1);
        periph_rd_en_o = popNow ? (NUM_PERIPH'(1) << grantIdx_q) : '0;
        out_wr_en_o    = popNow;
        out_data_o     = popNow ? {grantIdx_q, headWord[ADDR_LSB-1:0]} : '0;
    end

    // Arbitration FSM: pick in IDLE, move words in BURST, fall back to IDLE on any stop condition.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            grantIdx_q   <= '0;
            lastGrant_q  <= ADDR_W'(NUM_PERIPH - 1);
            burstCnt_q   <= '0;
            grantValid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (periph_ready_i && pickAny) begin
                        grantIdx_q   <= pickIdx;
                        burstCnt_q   <= '0;
                        state_q      <= BURST;
                        grantValid_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                BURST: begin
                    if (!periph_ready_i || !curEn || curEmpty) begin
                        state_q      <= IDLE;
                        lastGrant_q  <= grantIdx_q;
                        grantValid_q <= 1'b0;
                        busy_q       <= 1'b0;
                    end else if (popNow) begin
                        burstCnt_q <= burstCnt_d;
                        if (burstCnt_d == BURST_LAST) begin
                            state_q      <= IDLE;
                            lastGrant_q  <= grantIdx_q;
                            grantValid_q <= 1'b0;
                            busy_q       <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    grantValid_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign grant_valid_o = grantValid_q;
    assign busy_o        = busy_q;
    assign grant_idx_o   = grantIdx_q;

endmodule

// File: tb/tb_lycan_tx_arbiter.sv
// Bench for lycan_tx_arbiter: FIFO environment, transaction reference model and scoreboard.
module tb_lycan_tx_arbiter;

    localparam int NP = 8;
    localparam int AW = 3;
    localparam int MB = 16;

    typedef struct {
        int          cyc;
        int          idx;
        logic [31:0] word;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              periph_ready;
    logic [NP-1:0]     periph_en;
    logic [NP-1:0]     periph_empty;
    logic [NP*32-1:0]  periph_data;
    logic [NP-1:0]     periph_rd_en;
    logic              out_full;
    logic              out_wr_en;
    logic [31:0]       out_data;
    logic              grant_valid;
    logic [AW-1:0]     grant_idx;
    logic              busy;

    logic [31:0] fifoQ [NP][$];
    exp_t        expQ [$];
    int          burstIdx [$];
    int          burstLen [$];

    int checks = 0;
    int failures = 0;
    int cycle = 0;
    int writeCount = 0;
    logic started = 1'b0;
    logic prevWr = 1'b0;
    int   prevIdx = -1;
    logic [NP-1:0] popMask = '0;
    logic rstPrev = 1'b0;

    // stimulus knobs
    int pFull = 0;
    int pReadyDrop = 0;
    int pEnFlip = 0;
    int pRst = 0;
    logic rstForce = 1'b1;
    logic readyOn = 1'b1;
    logic [NP-1:0] enMask = '1;

    // reference model state
    int mGrant = -1;
    int mLast = NP - 1;
    int mIdx = 0;
    int mCount = 0;
    logic expValid = 1'b0;
    int expIdx = 0;

    always #5 clk = ~clk;

    lycan_tx_arbiter #(
        .NUM_PERIPH (NP),
        .ADDR_W     (AW),
        .MAX_BURST  (MB)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .periph_ready_i (periph_ready),
        .periph_en_i    (periph_en),
        .periph_empty_i (periph_empty),
        .periph_data_i  (periph_data),
        .periph_rd_en_o (periph_rd_en),
        .out_full_i     (out_full),
        .out_wr_en_o    (out_wr_en),
        .out_data_o     (out_data),
        .grant_valid_o  (grant_valid),
        .grant_idx_o    (grant_idx),
        .busy_o         (busy)
    );

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s cycle=%0d actual=0x%0h required=0x%0h", name, cycle, act, req);
        end
    endtask

    // Cycle-level behaviour: whoever holds the grant moves a word whenever it can,
    // a grant lasts at most MB words, and the search restarts after the last grantee.
    task automatic modelStep();
        int g;
        int c;
        logic [31:0] hw;
        expValid = (mGrant >= 0);
        expIdx   = mIdx;
        if (mGrant < 0) begin
            if (periph_ready) begin
                for (int k = 1; k <= NP; k++) begin
                    c = (mLast + k) % NP;
                    if (mGrant < 0 && periph_en[c] && !periph_empty[c]) begin
                        mGrant = c;
                        mIdx   = c;
                        mCount = 0;
                    end
                end
            end
        end else begin
            g = mGrant;
            if (!periph_ready || !periph_en[g] || periph_empty[g]) begin
                mLast  = g;
                mGrant = -1;
            end else if (!out_full) begin
                hw = fifoQ[g][0];
                expQ.push_back('{cyc: cycle, idx: g, word: {AW'(g), hw[31-AW:0]}});
                mCount++;
                if (mCount == MB) begin
                    mLast  = g;
                    mGrant = -1;
                end
            end
        end
        if (rst) begin
            mGrant = -1;
            mLast  = NP - 1;
            mIdx   = 0;
            mCount = 0;
        end
    endtask

    task automatic applyStimulus();
        int b;
        for (int i = 0; i < NP; i++) begin
            if (popMask[i] && fifoQ[i].size() > 0) begin
                void'(fifoQ[i].pop_front());
            end
        end
        cycle++;
        rstPrev      = rst;
        rst          = rstForce || ($urandom_range(99) < pRst);
        out_full     = ($urandom_range(99) < pFull);
        periph_ready = readyOn && ($urandom_range(99) >= pReadyDrop);
        if ($urandom_range(99) < pEnFlip) begin
            b = $urandom_range(NP - 1);
            enMask[b] = ~enMask[b];
        end
        periph_en = enMask;
        for (int i = 0; i < NP; i++) begin
            periph_empty[i] = (fifoQ[i].size() == 0);
            periph_data[i*32 +: 32] = (fifoQ[i].size() > 0) ? fifoQ[i][0] : $urandom();
        end
        modelStep();
    endtask

    task automatic checkOutput();
        exp_t e;
        checkValue("grant_valid", 32'(grant_valid), 32'(expValid));
        checkValue("busy", 32'(busy), 32'(expValid));
        checkValue("grant_idx", 32'(grant_idx), 32'(expIdx));
        checkValue("wr_eq_or_rd", 32'(out_wr_en), 32'(|periph_rd_en));
        checkValue("rd_onehot0", 32'($onehot0(periph_rd_en)), 32'(1));
        if (out_full) checkValue("no_write_full", 32'(out_wr_en), 32'(0));
        if (rstPrev) begin
            checkValue("data_after_rst", out_data, 32'(0));
            checkValue("rd_after_rst", 32'(periph_rd_en), 32'(0));
        end
        if (out_wr_en) begin
            writeCount++;
            if (!prevWr || prevIdx != int'(grant_idx)) begin
                burstIdx.push_back(int'(grant_idx));
                burstLen.push_back(0);
            end
            burstLen[burstLen.size()-1]++;
            prevIdx = int'(grant_idx);
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_write cycle=%0d actual=0x%0h required=none", cycle, out_data);
            end else begin
                e = expQ.pop_front();
                checkValue("write_cycle", 32'(cycle), 32'(e.cyc));
                checkValue("rd_en", 32'(periph_rd_en), 32'(NP'(1) << e.idx));
                checkValue("out_data", out_data, e.word);
            end
        end else if (expQ.size() > 0 && expQ[0].cyc <= cycle) begin
            checks++;
            failures++;
            $display("[TB] FAIL missing_write cycle=%0d actual=none required=0x%0h", cycle, expQ[0].word);
            void'(expQ.pop_front());
        end
        prevWr = out_wr_en;
    endtask

    task automatic runCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            applyStimulus();
            #2;
            popMask = periph_rd_en;
        end
    endtask

    function automatic logic anyData();
        logic r;
        r = 1'b0;
        for (int i = 0; i < NP; i++) if (fifoQ[i].size() > 0) r = 1'b1;
        return r;
    endfunction

    task automatic clearBursts();
        burstIdx.delete();
        burstLen.delete();
        writeCount = 0;
        prevWr = 1'b0;
        prevIdx = -1;
    endtask

    // Monitor: samples DUT outputs 1 time unit after each falling edge.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (started) checkOutput();
        end
    end

    initial begin
        int guard;
        int expLen [9] = '{16, 16, 16, 16, 16, 16, 8, 8, 8};
        int expOrd [9] = '{0, 1, 3, 0, 1, 3, 0, 1, 3};
        rst = 1'b1;
        periph_ready = 1'b0;
        periph_en = '0;
        periph_empty = '1;
        periph_data = '0;
        out_full = 1'b0;

        // reset state
        runCycles(2);
        started = 1'b1;
        runCycles(1);
        rstForce = 1'b0;

        // single requester with three words
        clearBursts();
        fifoQ[2].push_back(32'hA1B2C3D4);
        fifoQ[2].push_back(32'h5E6F7081);
        fifoQ[2].push_back(32'hFFFF0001);
        runCycles(10);
        checkValue("phaseB_writes", 32'(writeCount), 32'(3));
        checkValue("phaseB_bursts", 32'(burstIdx.size()), 32'(1));
        if (burstIdx.size() > 0) checkValue("phaseB_idx", 32'(burstIdx[0]), 32'(2));

        // three long requesters after a fresh reset
        for (int p = 0; p < NP; p++) begin
            if (p == 0 || p == 1 || p == 3) begin
                for (int w = 0; w < 40; w++) fifoQ[p].push_back($urandom());
            end
        end
        rstForce = 1'b1;
        runCycles(1);
        rstForce = 1'b0;
        clearBursts();
        runCycles(150);
        checkValue("phaseC_writes", 32'(writeCount), 32'(120));
        checkValue("phaseC_bursts", 32'(burstIdx.size()), 32'(9));
        for (int k = 0; k < 9 && k < burstIdx.size(); k++) begin
            checkValue($sformatf("phaseC_order%0d", k), 32'(burstIdx[k]), 32'(expOrd[k]));
            checkValue($sformatf("phaseC_len%0d", k), 32'(burstLen[k]), 32'(expLen[k]));
        end

        // random traffic with stalls, ready drops, enable flips and resets
        pFull = 25;
        pReadyDrop = 3;
        pEnFlip = 4;
        pRst = 1;
        for (int blk = 0; blk < 30; blk++) begin
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(1) == 1) begin
                    repeat ($urandom_range(20)) fifoQ[p].push_back($urandom());
                end
            end
            runCycles(64);
        end

        // drain everything
        pFull = 0;
        pReadyDrop = 0;
        pEnFlip = 0;
        pRst = 0;
        enMask = '1;
        guard = 0;
        while (anyData() && guard < 3000) begin
            runCycles(1);
            guard++;
        end
        checkValue("drained", 32'(anyData()), 32'(0));
        runCycles(4);
        checkValue("scoreboard_empty", 32'(expQ.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
